// File: rtl/sdram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter_if
//
// Bundles the two client request ports and the single controller-side port of
// sdram_port_arbiter.
//
// Client N signals (N = 0, 1):
//   cN_addr / cN_data / cN_byte_en : request address, write data, write mask
//   cN_wr / cN_rd                  : one-cycle write / read strobes
//   cN_busy                        : request register occupied
//   cN_q / cN_ready                : read data and one-cycle completion pulse
// Controller-side signals:
//   port_addr / port_data / port_byte_en / port_wr / port_rd : command out
//   port_available                 : controller accepts a command this cycle
//   port_q / port_ready            : returned read data and its valid pulse
//
// Modports:
//   slave  : the arbiter's view (clients in, controller command out)
//   master : the environment's view (drives clients, plays the controller)
// -----------------------------------------------------------------------------
interface sdram_port_arbiter_if #(
    parameter int ADDR_WIDTH    = 25,
    parameter int DATA_WIDTH    = 16,
    parameter int BYTE_EN_WIDTH = 2,
    parameter int OUTPUT_WIDTH  = 16
);

    logic [ADDR_WIDTH-1:0]    c0_addr;
    logic [DATA_WIDTH-1:0]    c0_data;
    logic [BYTE_EN_WIDTH-1:0] c0_byte_en;
    logic                     c0_wr;
    logic                     c0_rd;
    logic                     c0_busy;
    logic [OUTPUT_WIDTH-1:0]  c0_q;
    logic                     c0_ready;

    logic [ADDR_WIDTH-1:0]    c1_addr;
    logic [DATA_WIDTH-1:0]    c1_data;
    logic [BYTE_EN_WIDTH-1:0] c1_byte_en;
    logic                     c1_wr;
    logic                     c1_rd;
    logic                     c1_busy;
    logic [OUTPUT_WIDTH-1:0]  c1_q;
    logic                     c1_ready;

    logic [ADDR_WIDTH-1:0]    port_addr;
    logic [DATA_WIDTH-1:0]    port_data;
    logic [BYTE_EN_WIDTH-1:0] port_byte_en;
    logic                     port_wr;
    logic                     port_rd;
    logic                     port_available;
    logic [OUTPUT_WIDTH-1:0]  port_q;
    logic                     port_ready;

    modport slave (
        input  c0_addr, c0_data, c0_byte_en, c0_wr, c0_rd,
        output c0_busy, c0_q, c0_ready,
        input  c1_addr, c1_data, c1_byte_en, c1_wr, c1_rd,
        output c1_busy, c1_q, c1_ready,
        output port_addr, port_data, port_byte_en, port_wr, port_rd,
        input  port_available, port_q, port_ready
    );

    modport master (
        output c0_addr, c0_data, c0_byte_en, c0_wr, c0_rd,
        input  c0_busy, c0_q, c0_ready,
        output c1_addr, c1_data, c1_byte_en, c1_wr, c1_rd,
        input  c1_busy, c1_q, c1_ready,
        input  port_addr, port_data, port_byte_en, port_wr, port_rd,
        output port_available, port_q, port_ready
    );

endinterface

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Two-client front end for a single SDRAM controller port. Each client owns a
// one-entry request register; a round-robin arbiter issues one command at a
// time downstream, keeps at most one read outstanding and steers the returned
// data and completion pulse back to the owning client.
//
// Ports:
//   clk    : single clock, all logic on the rising edge
//   reset  : asynchronous, active-low reset
//   bus    : sdram_port_arbiter_if.slave
//            clients  cN_addr/data/byte_en/wr/rd in, cN_busy/q/ready out
//            port     port_addr/data/byte_en/wr/rd out,
//                     port_available/port_q/port_ready in
//
// Every output comes straight from a flop; client strobes and port_available
// only ever reach outputs through a register stage.
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH    = 25,
    parameter int DATA_WIDTH    = 16,
    parameter int BYTE_EN_WIDTH = 2,
    parameter int OUTPUT_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    sdram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Client-side inputs gathered into arrays so both clients share logic
    // ---------------------------------------------------------------------
    logic [1:0]               cli_wr_s;
    logic [1:0]               cli_rd_s;
    logic [ADDR_WIDTH-1:0]    cli_addr_s    [2];
    logic [DATA_WIDTH-1:0]    cli_data_s    [2];
    logic [BYTE_EN_WIDTH-1:0] cli_byte_en_s [2];

    assign cli_wr_s         = {bus.c1_wr, bus.c0_wr};
    assign cli_rd_s         = {bus.c1_rd, bus.c0_rd};
    assign cli_addr_s[0]    = bus.c0_addr;
    assign cli_addr_s[1]    = bus.c1_addr;
    assign cli_data_s[0]    = bus.c0_data;
    assign cli_data_s[1]    = bus.c1_data;
    assign cli_byte_en_s[0] = bus.c0_byte_en;
    assign cli_byte_en_s[1] = bus.c1_byte_en;

    // ---------------------------------------------------------------------
    // Request registers (one entry per client)
    // ---------------------------------------------------------------------
    logic [1:0]               req_valid_r;
    logic [1:0]               req_wr_r;
    logic [ADDR_WIDTH-1:0]    req_addr_r    [2];
    logic [DATA_WIDTH-1:0]    req_data_r    [2];
    logic [BYTE_EN_WIDTH-1:0] req_byte_en_r [2];

    // ---------------------------------------------------------------------
    // Arbiter / downstream registers
    // ---------------------------------------------------------------------
    state_t                   state_r;
    logic                     owner_r;
    logic                     last_grant_r;
    logic [ADDR_WIDTH-1:0]    port_addr_r;
    logic [DATA_WIDTH-1:0]    port_data_r;
    logic [BYTE_EN_WIDTH-1:0] port_byte_en_r;
    logic                     port_wr_r;
    logic                     port_rd_r;
    logic [1:0]               ready_r;
    logic [OUTPUT_WIDTH-1:0]  q_r [2];

    // Combinational decisions shared by the request registers and the FSM
    logic [1:0]               done_s;
    logic                     grant_s;

    // Completion this cycle: accepted write, or read data returned while
    // waiting. port_ready outside WAIT_RD never completes anything.
    always_comb begin
        done_s = 2'b00;
        case (state_r)
            ISSUE: begin
                if (bus.port_available && port_wr_r) begin
                    done_s[owner_r] = 1'b1;
                end else begin
                    done_s = 2'b00;
                end
            end
            WAIT_RD: begin
                if (bus.port_ready) begin
                    done_s[owner_r] = 1'b1;
                end else begin
                    done_s = 2'b00;
                end
            end
            default: begin
                done_s = 2'b00;
            end
        endcase
    end

    // Round-robin winner: on contention the client not granted last wins,
    // otherwise whichever client is pending.
    always_comb begin
        grant_s = 1'b0;
        if (req_valid_r == 2'b11) begin
            grant_s = ~last_grant_r;
        end else if (req_valid_r[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Request capture and release. A completing client cannot be strobing
    // into a full register, so release and capture never collide; a client
    // may re-strobe in the cycle its busy is seen low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid_r <= 2'b00;
            req_wr_r    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                req_addr_r[i]    <= {ADDR_WIDTH{1'b0}};
                req_data_r[i]    <= {DATA_WIDTH{1'b0}};
                req_byte_en_r[i] <= {BYTE_EN_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (done_s[i]) begin
                    req_valid_r[i] <= 1'b0;
                end else if (!req_valid_r[i] && (cli_wr_s[i] || cli_rd_s[i])) begin
                    req_valid_r[i]   <= 1'b1;
                    // wr wins when both strobes are high
                    req_wr_r[i]      <= cli_wr_s[i];
                    req_addr_r[i]    <= cli_addr_s[i];
                    req_data_r[i]    <= cli_data_s[i];
                    req_byte_en_r[i] <= cli_byte_en_s[i];
                end
            end
        end
    end

    // Arbiter FSM with registered downstream command, read data and
    // completion pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            owner_r        <= 1'b0;
            last_grant_r   <= 1'b1;
            port_addr_r    <= {ADDR_WIDTH{1'b0}};
            port_data_r    <= {DATA_WIDTH{1'b0}};
            port_byte_en_r <= {BYTE_EN_WIDTH{1'b0}};
            port_wr_r      <= 1'b0;
            port_rd_r      <= 1'b0;
            ready_r        <= 2'b00;
            q_r[0]         <= {OUTPUT_WIDTH{1'b0}};
            q_r[1]         <= {OUTPUT_WIDTH{1'b0}};
        end else begin
            // completion pulse lands one cycle after the completing event
            ready_r <= done_s;
            case (state_r)
                IDLE: begin
                    if (|req_valid_r) begin
                        port_addr_r    <= req_addr_r[grant_s];
                        port_data_r    <= req_data_r[grant_s];
                        port_byte_en_r <= req_byte_en_r[grant_s];
                        port_wr_r      <= req_wr_r[grant_s];
                        port_rd_r      <= ~req_wr_r[grant_s];
                        owner_r        <= grant_s;
                        last_grant_r   <= grant_s;
                        state_r        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // command and its payload are held until accepted
                    if (bus.port_available) begin
                        port_wr_r <= 1'b0;
                        port_rd_r <= 1'b0;
                        state_r   <= port_wr_r ? IDLE : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (bus.port_ready) begin
                        q_r[owner_r] <= bus.port_q;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    port_wr_r <= 1'b0;
                    port_rd_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.c0_busy      = req_valid_r[0];
    assign bus.c1_busy      = req_valid_r[1];
    assign bus.c0_ready     = ready_r[0];
    assign bus.c1_ready     = ready_r[1];
    assign bus.c0_q         = q_r[0];
    assign bus.c1_q         = q_r[1];
    assign bus.port_addr    = port_addr_r;
    assign bus.port_data    = port_data_r;
    assign bus.port_byte_en = port_byte_en_r;
    assign bus.port_wr      = port_wr_r;
    assign bus.port_rd      = port_rd_r;

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-client front end that sits directly upstream of the SDRAM port wrapper and drives its single controller-side request port. Each client gets a one-entry request register. A round-robin arbiter issues one command at a time downstream, tracks the single outstanding read, and routes the returned read data and completion pulse back to the client that owns it. This lets a video fetcher and a CPU-side master share one SDRAM controller without either knowing about the other.

## Interface
Parameters:
- ADDR_WIDTH, 25, port address width; matches the controller's port address.
- DATA_WIDTH, 16, write data width.
- BYTE_EN_WIDTH, 2, byte-enable width.
- OUTPUT_WIDTH, 16, read data width; equals burst length × data width downstream.

Ports (clients indexed by suffix 0/1; per-client ports listed once as cN):
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cN_addr  in  ADDR_WIDTH  request address.
- cN_data  in  DATA_WIDTH  write data.
- cN_byte_en  in  BYTE_EN_WIDTH  write byte mask.
- cN_wr  in  1  one-cycle write strobe.
- cN_rd  in  1  one-cycle read strobe.
- cN_busy  out  1  request register occupied; strobes are ignored while high.
- cN_q  out  OUTPUT_WIDTH  read data; valid when cN_ready pulses, and held until the next read completion for that client.
- cN_ready  out  1  one-cycle completion pulse: write accepted downstream, or read data returned.
- port_addr  out  ADDR_WIDTH  downstream address.
- port_data  out  DATA_WIDTH  downstream write data.
- port_byte_en  out  BYTE_EN_WIDTH  downstream byte mask.
- port_wr  out  1  downstream write command.
- port_rd  out  1  downstream read command.
- port_available  in  1  downstream can accept a command this cycle.
- port_q  in  OUTPUT_WIDTH  downstream read data.
- port_ready  in  1  downstream read-data-valid pulse.

## Operation
- Capture: if cN_wr or cN_rd is high while cN_busy is low, the block latches addr, data, byte_en and the op into client N's request register and sets busy. If wr and rd are both high, the request is treated as a write. Strobes while busy are dropped.
- Arbiter FSM states are IDLE, ISSUE and WAIT_RD.
  - IDLE → ISSUE: when at least one request register is pending. The FSM picks a winner, loads the port_* registers from it, and records the owner.
  - Round-robin: when both clients are pending, the client not granted last wins. After reset, last_grant = 1, so client 0 wins first.
  - ISSUE: port_wr or port_rd is held high, with address, data and mask stable, until a cycle with port_available = 1. That cycle is the acceptance.
  - ISSUE → IDLE on accepted write. In the next cycle: owner's cN_ready pulses, cN_busy clears, and port_wr is low.
  - ISSUE → WAIT_RD on accepted read. port_rd is low in the next cycle.
  - WAIT_RD → IDLE on port_ready. The FSM registers port_q into the owner's cN_q; in the next cycle cN_ready pulses and cN_busy clears.
- Only one read is outstanding at a time. port_ready seen outside WAIT_RD is ignored.
- A client may re-strobe in the same cycle its busy is seen low (the cycle of its ready pulse).

## Timing
- Reset values: all cN_busy, cN_ready, port_wr and port_rd are 0; all cN_q, port_addr, port_data and port_byte_en are 0; FSM is IDLE; last_grant = 1.
- Reset asserted mid-operation: pending and in-flight requests are discarded with no ready pulse. A late port_ready after release is ignored.
- Client strobe at cycle T: busy = 1 at T+1. Earliest port command asserted at T+2.
- Write with port_available = 1 at T+2: cN_ready pulses at T+3, and busy = 0 at T+3.
- Read accepted at A, port_ready at R > A: cN_q valid and cN_ready pulse at R+1.
- Back-to-back: after a completion, a pending other client's command appears 1 cycle after the return to IDLE (IDLE costs one cycle).
- All outputs are registered; there is no combinational path from client inputs or port_available to any output.

## Test plan
- Single write, client 0, addr 0x0000123, data 0xBEEF, byte_en 2'b11, available tied high: port_wr high exactly at T+2 with those values; c0_ready pulses at T+3.
- Single read, client 1, addr 0x1000000; port_ready 5 cycles after acceptance with port_q 0xA5A5: c1_q = 0xA5A5 and c1_ready pulse one cycle later; c0_ready stays 0.
- Both clients strobe reads in the same cycle out of reset: client 0 is issued first, then client 1. Repeat with both strobing again: client 0 then client 1 again, and neither starves over 8 rounds.
- port_available low for 4 cycles during ISSUE: port_wr/port_rd and address stay stable for all 4 cycles. Exactly one acceptance occurs and exactly one ready pulse follows.
- Strobe while busy (c0_wr with different data during an outstanding read): dropped, and the original read completes with its own data. Spurious port_ready in IDLE produces no ready pulse.
- Reset asserted while in WAIT_RD: all outputs go to reset values immediately. A port_ready arriving after release yields no client ready pulse.
